// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter sharing the 32-bit 4:1 operand mux between four requesters.
// Grants are registered, capped at MAX_HOLD cycles, and separated by a turnaround cycle.
module mux_sel_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_f,
   input  logic [3:0]       req,
   input  logic [3:0]       rel,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic             busy,
   output logic [CNT_W-1:0] hold_cnt,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_d;
   logic [3:0]       gnt_d;
   logic [1:0]       sel_d, last, last_d, win, cand;
   logic             win_vld, busy_d, timeout_d, vol, forced;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
         timeout  <= 1'b0;
         last     <= 2'd3;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         sel      <= sel_d;
         busy     <= busy_d;
         hold_cnt <= cnt_d;
         timeout  <= timeout_d;
         last     <= last_d;
      end
   end

   always_comb begin
      state_d   = state;
      gnt_d     = gnt;
      sel_d     = sel;
      busy_d    = busy;
      cnt_d     = hold_cnt;
      timeout_d = 1'b0;
      last_d    = last;
      win       = '0;
      win_vld   = 1'b0;
      cand      = '0;

      // Scan from last+1 with wrap; i=4 lands back on last, giving it lowest priority.
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = last + i[1:0];
         if (!win_vld && req[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end

      vol    = rel[sel] | ~req[sel];
      forced = (hold_cnt == HOLD_LAST);

      case (state)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (win_vld) begin
               state_d = GRANT;
               gnt_d   = 4'(4'b0001 << win);
               sel_d   = win;
               busy_d  = 1'b1;
               last_d  = win;
            end
         end
         GRANT: begin
            if (vol || forced) begin
               state_d   = TURN;
               gnt_d     = '0;
               busy_d    = 1'b0;
               cnt_d     = '0;
               timeout_d = ~vol;
            end else begin
               cnt_d = hold_cnt + CNT_W'(1);
            end
         end
         TURN: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

endmodule
